fb_sdram_arbiter: RTL and testbench

//  Shares the single SDRAM controller command port between the camera frame-buffer writer and the

---
 rtl/fb_sdram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fb_sdram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sdram_arbiter.sv
// fb_sdram_arbiter: shares the SDRAM command port between the frame-buffer writer and the line-buffer reader.
// Optional build macro FB_ARB_STATS_EN adds rd_bursts/wr_bursts/forced_writes counter ports.
//
//  state | meaning
//  IDLE  | arbitrate pending requests, latch winner's addr/len/direction
//  CMD   | mem_cmd_valid high with stable payload until mem_cmd_ready
//  BUSY  | command accepted, waiting for mem_done
//  ZERO  | zero-length request: grant and done together, no SDRAM access
module fb_sdram_arbiter #(
    parameter int ADDR_WIDTH  = 22,
    parameter int LEN_WIDTH   = 9,
    parameter int MAX_WR_WAIT = 64
) (
    input  logic                  clk_in,
    input  logic                  resetn,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic                  rd_grant,
    output logic                  rd_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    output logic                  wr_grant,
    output logic                  wr_done,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_write,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [LEN_WIDTH-1:0]  mem_cmd_len,
    input  logic                  mem_done
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]           rd_bursts,
    output logic [15:0]           wr_bursts,
    output logic [15:0]           forced_writes
`endif
);

    localparam int WW = $clog2(MAX_WR_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WR_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_BUSY = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    sel_wr_q, sel_wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    done_q, done_d;
    logic [WW-1:0]           wr_wait_q, wr_wait_d;
    logic                    wait_sat;
    logic                    grant;
    logic                    done_any;

    assign wait_sat = (wr_wait_q == WAIT_MAX);

    always_comb begin
        state_d  = state_q;
        sel_wr_d = sel_wr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    // reads win unless the writer has aged out
                    sel_wr_d = wr_req && (!rd_req || wait_sat);
                    addr_d   = sel_wr_d ? wr_addr : rd_addr;
                    len_d    = sel_wr_d ? wr_len : rd_len;
                    state_d  = (len_d == '0) ? S_ZERO : S_CMD;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ZERO: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant    = ((state_q == S_CMD) && mem_cmd_ready) || (state_q == S_ZERO);
    assign done_any = done_q || (state_q == S_ZERO);

    assign rd_grant      = grant && !sel_wr_q;
    assign wr_grant      = grant && sel_wr_q;
    assign rd_done       = done_any && !sel_wr_q;
    assign wr_done       = done_any && sel_wr_q;
    assign mem_cmd_valid = (state_q == S_CMD);
    assign mem_cmd_write = sel_wr_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_len   = len_q;

    always_comb begin
        wr_wait_d = wr_wait_q;
        if (wr_grant) begin
            wr_wait_d = '0;
        end else if (wr_req && !wait_sat) begin
            wr_wait_d = wr_wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            sel_wr_q  <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            wr_wait_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_wr_q  <= sel_wr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            done_q    <= done_d;
            wr_wait_q <= wr_wait_d;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic        force_sel;
    logic [15:0] rd_bursts_q, wr_bursts_q, forced_q;

    // a write counts as forced only when a read was also waiting
    assign force_sel = (state_q == S_IDLE) && rd_req && wr_req && wait_sat;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            rd_bursts_q <= '0;
            wr_bursts_q <= '0;
            forced_q    <= '0;
        end else begin
            if (rd_done) begin
                rd_bursts_q <= rd_bursts_q + 16'd1;
            end
            if (wr_done) begin
                wr_bursts_q <= wr_bursts_q + 16'd1;
            end
            if (force_sel) begin
                forced_q <= forced_q + 16'd1;
            end
        end
    end

    assign rd_bursts     = rd_bursts_q;
    assign wr_bursts     = wr_bursts_q;
    assign forced_writes = forced_q;
`endif

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Testbench for fb_sdram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fb_sdram_arbiter;

    localparam int AW   = 22;
    localparam int LW   = 9;
    localparam int MAXW = 64;

    logic          clk_in = 1'b0;
    logic          resetn;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [LW-1:0] rd_len, wr_len;
    logic          rd_grant, rd_done, wr_grant, wr_done;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_write, mem_done;
    logic [AW-1:0] mem_cmd_addr;
    logic [LW-1:0] mem_cmd_len;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   rd_bursts, wr_bursts, forced_writes;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    fb_sdram_arbiter #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .MAX_WR_WAIT(MAXW)
    ) dut (
        .clk_in       (clk_in),
        .resetn       (resetn),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_grant     (rd_grant),
        .rd_done      (rd_done),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_len       (wr_len),
        .wr_grant     (wr_grant),
        .wr_done      (wr_done),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(mem_cmd_write),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_len  (mem_cmd_len),
        .mem_done     (mem_done)
`ifdef FB_ARB_STATS_EN
        ,
        .rd_bursts    (rd_bursts),
        .wr_bursts    (wr_bursts),
        .forced_writes(forced_writes)
`endif
    );

    // inputs change 1 time unit after the rising edge, outputs are sampled at the falling edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        rd_req        = 1'b0;
        wr_req        = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic new_rd(input bit force_mode);
        rd_req  = 1'b1;
        rd_addr = AW'($urandom);
        rd_len  = force_mode ? LW'($urandom_range(1, 2)) : LW'($urandom_range(0, 6));
    endtask

    task automatic new_wr(input bit force_mode);
        wr_req  = 1'b1;
        wr_addr = AW'($urandom);
        wr_len  = force_mode ? LW'($urandom_range(1, 3)) : LW'($urandom_range(0, 6));
    endtask

    task automatic test_reset();
        logic [AW+LW+5:0] outs;
        resetn        = 1'b0;
        rd_req        = 1'b1;
        rd_addr       = AW'(32'h55);
        rd_len        = LW'(4);
        wr_req        = 1'b1;
        wr_addr       = AW'(32'hAA);
        wr_len        = LW'(2);
        mem_cmd_ready = 1'b1;
        mem_done      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #4;
            outs = {rd_grant, rd_done, wr_grant, wr_done, mem_cmd_valid, mem_cmd_write,
                    mem_cmd_addr, mem_cmd_len};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h required=0", i, outs);
            end
        end
        tick();
        resetn        = 1'b1;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        #4;
        checks++;
        if (mem_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got valid=%b required=0", mem_cmd_valid);
        end
        tick();
        #4;
        checks++;
        if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len} !== {1'b1, 1'b0, AW'(32'h55), LW'(4)}) begin
            failures++;
            $display("FAIL reset_first_cmd got valid=%b write=%b addr=%h len=%0d required 1 0 55 4",
                     mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len);
        end
        checks++;
        if ({rd_grant, wr_grant} !== 2'b00) begin
            failures++;
            $display("FAIL reset_no_grant_unready got=%b required=00", {rd_grant, wr_grant});
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic test_single_read();
        logic [4:0] got, req;
        do_reset();
        rd_addr       = AW'(32'h1000);
        rd_len        = LW'(16);
        mem_cmd_ready = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            rd_req   = (k <= 1);
            mem_done = (k == 20);
            #4;
            got = {mem_cmd_valid, rd_grant, rd_done, wr_grant, wr_done};
            req = {k == 1, k == 1, k == 21, 1'b0, 1'b0};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL single_read k=%0d got=%b required=%b", k, got, req);
            end
            if (k == 1) begin
                checks++;
                if ({mem_cmd_write, mem_cmd_addr, mem_cmd_len} !== {1'b0, AW'(32'h1000), LW'(16)}) begin
                    failures++;
                    $display("FAIL single_read_payload got write=%b addr=%h len=%0d required 0 1000 16",
                             mem_cmd_write, mem_cmd_addr, mem_cmd_len);
                end
            end
            tick();
        end
        mem_done = 1'b0;
    endtask

    task automatic test_zero_len_write();
        logic [4:0] got, req;
        do_reset();
        wr_addr       = AW'(32'h2222);
        wr_len        = '0;
        mem_cmd_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            wr_req = (k <= 1);
            #4;
            got = {mem_cmd_valid, rd_grant, rd_done, wr_grant, wr_done};
            req = {1'b0, 1'b0, 1'b0, k == 1, k == 1};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL zero_len_write k=%0d got=%b required=%b", k, got, req);
            end
            tick();
        end
    endtask

    task automatic test_ready_stall_and_reset();
        logic [4:0] got, req;
        do_reset();
        rd_addr = AW'(32'h3ABCD);
        rd_len  = LW'(7);
        for (int k = 0; k <= 17; k++) begin
            rd_req        = (k <= 11);
            mem_cmd_ready = (k == 11);
            resetn        = (k != 14);
            mem_done      = (k == 15);
            #4;
            got = {mem_cmd_valid, rd_grant, rd_done, wr_grant, wr_done};
            req = {(k >= 1) && (k <= 11), k == 11, 1'b0, 1'b0, 1'b0};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL stall_reset k=%0d got=%b required=%b", k, got, req);
            end
            if (k >= 1 && k <= 11) begin
                checks++;
                if ({mem_cmd_write, mem_cmd_addr, mem_cmd_len} !== {1'b0, AW'(32'h3ABCD), LW'(7)}) begin
                    failures++;
                    $display("FAIL stall_payload k=%0d got write=%b addr=%h len=%0d", k,
                             mem_cmd_write, mem_cmd_addr, mem_cmd_len);
                end
            end
            if (k == 14) begin
                checks++;
                if ({mem_cmd_addr, mem_cmd_len} !== '0) begin
                    failures++;
                    $display("FAIL stall_reset_clears got addr=%h len=%0d required 0 0",
                             mem_cmd_addr, mem_cmd_len);
                end
            end
            tick();
        end
        mem_done = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [4:0] got, req;
        do_reset();
        rd_addr       = AW'(32'h100);
        rd_len        = LW'(2);
        wr_addr       = AW'(32'h200);
        wr_len        = LW'(3);
        mem_cmd_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            rd_req   = (k <= 1);
            wr_req   = (k <= 4);
            mem_done = (k == 2) || (k == 5);
            #4;
            got = {mem_cmd_valid, rd_grant, wr_grant, rd_done, wr_done};
            req = {(k == 1) || (k == 4), k == 1, k == 4, k == 3, k == 6};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL simultaneous k=%0d got=%b required=%b", k, got, req);
            end
            if (k == 4) begin
                checks++;
                if ({mem_cmd_write, mem_cmd_addr, mem_cmd_len} !== {1'b1, AW'(32'h200), LW'(3)}) begin
                    failures++;
                    $display("FAIL simultaneous_wr_payload got write=%b addr=%h len=%0d required 1 200 3",
                             mem_cmd_write, mem_cmd_addr, mem_cmd_len);
                end
            end
            tick();
        end
        mem_done = 1'b0;
    endtask

    // Transaction-level model: one transaction open at a time; arbitration happens in any
    // cycle with no open transaction (at or after free_at) and at least one request.
    task automatic run_traffic(input bit force_mode, input int ncyc, output int n_wr_dut);
        int            free_at, wr_rise, mem_done_at, done_pulse_at, tx_start, wait_k;
        bit            open_tx, tx_dir, tx_acc, rd_gseen, wr_gseen, prev_wr;
        bit            exp_valid, exp_grant, exp_done;
        logic [AW-1:0] tx_addr;
        logic [LW-1:0] tx_len;
        n_wr_dut = 0;
        do_reset();
        free_at = 0; wr_rise = 0; mem_done_at = -10; done_pulse_at = -10; tx_start = 0;
        open_tx = 0; tx_dir = 0; tx_acc = 0; rd_gseen = 0; wr_gseen = 0; prev_wr = 0;
        tx_addr = '0; tx_len = '0;
        for (int k = 0; k < ncyc; k++) begin
            if (rd_gseen) begin
                if (force_mode) new_rd(1'b1);
                else rd_req = 1'b0;
            end else if (!rd_req && (force_mode || $urandom_range(0, 3) != 0)) begin
                new_rd(force_mode);
            end
            if (wr_gseen) wr_req = 1'b0;
            else if (!wr_req && $urandom_range(0, 2) == 0) new_wr(force_mode);
            mem_cmd_ready = force_mode ? 1'b1 : 1'($urandom_range(0, 1));
            mem_done      = (k == mem_done_at);
            if (wr_req && !prev_wr) wr_rise = k;
            prev_wr = wr_req;

            exp_valid = open_tx && (tx_len != 0) && (k >= tx_start) && !tx_acc;
            exp_grant = (open_tx && (tx_len == 0) && (k == tx_start)) || (exp_valid && mem_cmd_ready);
            exp_done  = open_tx && (((tx_len == 0) && (k == tx_start)) || (tx_acc && (k == done_pulse_at)));
            #4;
            checks++;
            if ({rd_grant, wr_grant} !== {exp_grant && !tx_dir, exp_grant && tx_dir}) begin
                failures++;
                $display("FAIL traffic_grant k=%0d got=%b required=%b", k, {rd_grant, wr_grant},
                         {exp_grant && !tx_dir, exp_grant && tx_dir});
            end
            checks++;
            if ({rd_done, wr_done} !== {exp_done && !tx_dir, exp_done && tx_dir}) begin
                failures++;
                $display("FAIL traffic_done k=%0d got=%b required=%b", k, {rd_done, wr_done},
                         {exp_done && !tx_dir, exp_done && tx_dir});
            end
            checks++;
            if (mem_cmd_valid !== exp_valid) begin
                failures++;
                $display("FAIL traffic_valid k=%0d got=%b required=%b", k, mem_cmd_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if ({mem_cmd_write, mem_cmd_addr, mem_cmd_len} !== {tx_dir, tx_addr, tx_len}) begin
                    failures++;
                    $display("FAIL traffic_payload k=%0d got write=%b addr=%h len=%0d required %b %h %0d",
                             k, mem_cmd_write, mem_cmd_addr, mem_cmd_len, tx_dir, tx_addr, tx_len);
                end
            end
            rd_gseen = rd_grant;
            wr_gseen = wr_grant;
            if (wr_grant) n_wr_dut++;

            if (exp_valid && mem_cmd_ready) begin
                tx_acc        = 1'b1;
                mem_done_at   = k + (force_mode ? 1 : int'($urandom_range(1, 4)));
                done_pulse_at = mem_done_at + 1;
            end
            if (exp_done) begin
                open_tx = 1'b0;
                free_at = (tx_len == 0) ? k + 1 : k;
            end
            if (!open_tx && (k >= free_at) && (rd_req || wr_req)) begin
                wait_k   = wr_req ? (((k - wr_rise) >= MAXW) ? MAXW : (k - wr_rise)) : 0;
                tx_dir   = wr_req && (!rd_req || (wait_k == MAXW));
                tx_addr  = tx_dir ? wr_addr : rd_addr;
                tx_len   = tx_dir ? wr_len : rd_len;
                tx_start = k + 1;
                tx_acc   = 1'b0;
                open_tx  = 1'b1;
            end
            tick();
        end
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        mem_done = 1'b0;
    endtask

    task automatic test_forced_write();
        int n_wr;
        run_traffic(1'b1, 400, n_wr);
        checks++;
        if (n_wr < 3) begin
            failures++;
            $display("FAIL forced_write_count got=%0d required>=3", n_wr);
        end
    endtask

    task automatic test_random_traffic();
        int n_wr;
        run_traffic(1'b0, 3000, n_wr);
        checks++;
        if (n_wr < 1) begin
            failures++;
            $display("FAIL random_write_served got=%0d required>=1", n_wr);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        rd_req        = 1'b0;
        wr_req        = 1'b0;
        rd_addr       = '0;
        wr_addr       = '0;
        rd_len        = '0;
        wr_len        = '0;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        test_reset();
        test_single_read();
        test_zero_len_write();
        test_ready_stall_and_reset();
        test_simultaneous();
        test_forced_write();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
